// File: rtl/arm_fetch_pkg.sv
// Shared constants and FSM state type for the instruction fetch stage.
package arm_fetch_pkg;

  localparam logic [31:0] ARM_RESET_PC = 32'h0000_0000;
  localparam int unsigned ARM_INST_W   = 32;
  localparam logic [31:0] ARM_PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    FETCH_IDLE    = 2'd0,
    FETCH_REQ     = 2'd1,
    FETCH_DISCARD = 2'd2
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/arm_fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} pairs; head is read directly from storage.
module arm_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Flush wins over any concurrent push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/arm_fetch.sv
// Instruction fetch stage: owns fetch PC, issues single-outstanding imem reads,
// buffers returned words with their PCs and presents them to decode.
module arm_fetch
  import arm_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = ARM_RESET_PC,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_ack,
  input  logic [ARM_INST_W-1:0] imem_rdata,
  output logic [ARM_INST_W-1:0] inst,
  output logic [31:0]           inst_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc
);

  localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [31:0]     fetch_pc;
  logic [31:0]     fetch_pc_next;
  logic [31:0]     pc_plus;
  logic [31:0]     redirect_target;
  logic            req_next;
  logic [31:0]     addr_next;

  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            space;
  logic [ARM_INST_W+31:0] fifo_dout;
  logic            unused_ok;

  assign pc_plus         = fetch_pc + ARM_PC_INC;
  assign redirect_target = word_align(redirect_pc);

  // A redirect drops both the returning word and any decode pop.
  assign push = (state == FETCH_REQ) && imem_ack && !redirect;
  assign pop  = inst_valid && inst_ready && !redirect;

  // Occupancy after this cycle's push/pop/flush; a request is only issued
  // when its response is guaranteed a free slot.
  always_comb begin
    count_next = count;
    if (redirect) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  assign space = (count_next < CW'(BUF_DEPTH));

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_next      = imem_req;
    addr_next     = imem_addr;
    unique case (state)
      FETCH_IDLE: begin
        if (redirect) begin
          fetch_pc_next = redirect_target;
        end else if (space) begin
          state_next = FETCH_REQ;
          req_next   = 1'b1;
          addr_next  = fetch_pc;
        end
      end
      FETCH_REQ: begin
        if (redirect) begin
          fetch_pc_next = redirect_target;
          if (imem_ack) begin
            state_next = FETCH_IDLE;
            req_next   = 1'b0;
          end else begin
            state_next = FETCH_DISCARD;
          end
        end else if (imem_ack) begin
          fetch_pc_next = pc_plus;
          if (space) begin
            addr_next = pc_plus;
          end else begin
            state_next = FETCH_IDLE;
            req_next   = 1'b0;
          end
        end
      end
      FETCH_DISCARD: begin
        if (redirect) begin
          fetch_pc_next = redirect_target;
        end
        if (imem_ack) begin
          state_next = FETCH_IDLE;
          req_next   = 1'b0;
        end
      end
      default: begin
        state_next = FETCH_IDLE;
        req_next   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH_IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      state     <= state_next;
      fetch_pc  <= fetch_pc_next;
      imem_req  <= req_next;
      imem_addr <= addr_next;
    end
  end

  arm_fetch_fifo #(
    .WIDTH (ARM_INST_W + 32),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({imem_rdata, imem_addr}),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (count)
  );

  assign inst       = fifo_dout[ARM_INST_W+31:32];
  assign inst_pc    = fifo_dout[31:0];
  assign inst_valid = !fifo_empty;

  assign unused_ok = &{1'b0, redirect_pc[1:0], fifo_full};

endmodule

// File: tb/tb_arm_fetch.sv
// Directed self-checking bench for arm_fetch.
module tb_arm_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ack = 1'b0;
  logic [31:0] w_rdata = '0;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;
  logic        w_valid;
  logic        w_ready = 1'b0;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arm_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  arm_fetch #(
    .RESET_PC  (32'hFFFF_FFFC),
    .BUF_DEPTH (2)
  ) u_wrap (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_ack    (w_ack),
    .imem_rdata  (w_rdata),
    .inst        (w_inst),
    .inst_pc     (w_inst_pc),
    .inst_valid  (w_valid),
    .inst_ready  (w_ready),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0; w_ack = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({imem_req, inst_valid} !== 2'b00 || imem_addr !== 32'h0 ||
          inst !== 32'h0 || inst_pc !== 32'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: req=%b valid=%b addr=%h inst=%h pc=%h expected all 0",
                 c, imem_req, inst_valid, imem_addr, inst, inst_pc);
      end
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_first_req: req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    inst_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_req%0d: req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k));
      end
      imem_ack = 1'b1;
      imem_rdata = 32'hE000_0000 + 32'(k);
      step();
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'hE000_0000 + 32'(k) || inst_pc !== 32'(4 * k)) begin
        errors++;
        $display("FAIL stream_out%0d: valid=%b inst=%h pc=%h expected valid=1 inst=%h pc=%h",
                 k, inst_valid, inst, inst_pc, 32'hE000_0000 + 32'(k), 32'(4 * k));
      end
    end
    imem_ack = 1'b0;
    inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    inst_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL bp_req%0d: req=%b addr=%h expected req=1 addr=%h", k, imem_req, imem_addr, 32'(4 * k));
      end
      imem_ack = 1'b1;
      imem_rdata = 32'hA000_0000 + 32'(k);
      step();
    end
    imem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
        errors++;
        $display("FAIL bp_full%0d: req=%b valid=%b pc=%h expected req=0 valid=1 pc=00000000",
                 c, imem_req, inst_valid, inst_pc);
      end
      step();
    end
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8 || inst_pc !== 32'h4 || inst !== 32'hA000_0001) begin
      errors++;
      $display("FAIL bp_refill: req=%b addr=%h pc=%h inst=%h expected req=1 addr=00000008 pc=00000004 inst=a0000001",
               imem_req, imem_addr, inst_pc, inst);
    end
    repeat (3) step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL bp_hold: req=%b addr=%h expected req=1 addr=00000008", imem_req, imem_addr);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hA000_0002;
    step();
    imem_ack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (imem_req !== 1'b0) begin
        errors++;
        $display("FAIL bp_single%0d: req=%b expected 0", c, imem_req);
      end
      step();
    end
    // flush from IDLE while full
    redirect = 1'b1;
    redirect_pc = 32'h0000_0041;
    step();
    redirect = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL idle_redirect_flush: valid=%b req=%b expected 0 0", inst_valid, imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL idle_redirect_req: req=%b addr=%h expected req=1 addr=00000040", imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    inst_ready = 1'b1;
    imem_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      imem_rdata = 32'hB000_0000 + 32'(k);
      step();
    end
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL rw_pre: req=%b addr=%h expected req=1 addr=00000010", imem_req, imem_addr);
    end
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || inst_valid !== 1'b0) begin
        errors++;
        $display("FAIL rw_discard%0d: req=%b addr=%h valid=%b expected req=1 addr=00000010 valid=0",
                 c, imem_req, imem_addr, inst_valid);
      end
      step();
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_dropped: req=%b valid=%b expected 0 0", imem_req, inst_valid);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL rw_newreq: req=%b addr=%h valid=%b expected req=1 addr=00000100 valid=0",
               imem_req, imem_addr, inst_valid);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hE100_0000;
    step();
    imem_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== 32'hE100_0000) begin
      errors++;
      $display("FAIL rw_first: valid=%b pc=%h inst=%h expected valid=1 pc=00000100 inst=e1000000",
               inst_valid, inst_pc, inst);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    inst_ready = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hC000_0000;
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL sim_pre: valid=%b pc=%h addr=%h expected valid=1 pc=00000000 addr=00000004",
               inst_valid, inst_pc, imem_addr);
    end
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    imem_rdata = 32'hBAD0_0BAD;
    step();
    redirect = 1'b0;
    imem_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL sim_flush: valid=%b req=%b expected 0 0", inst_valid, imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL sim_newreq: req=%b addr=%h valid=%b expected req=1 addr=00000200 valid=0",
               imem_req, imem_addr, inst_valid);
    end
    imem_ack = 1'b1;
    imem_rdata = 32'hE200_0000;
    step();
    imem_ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== 32'hE200_0000) begin
      errors++;
      $display("FAIL sim_first: valid=%b pc=%h inst=%h expected valid=1 pc=00000200 inst=e2000000",
               inst_valid, inst_pc, inst);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    w_ready = 1'b1;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first: req=%b addr=%h expected req=1 addr=fffffffc", w_req, w_addr);
    end
    w_ack = 1'b1;
    w_rdata = 32'hE300_0000;
    step();
    w_ack = 1'b0;
    checks++;
    if (w_req !== 1'b1 || w_addr !== 32'h0 || w_valid !== 1'b1 || w_inst_pc !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_second: req=%b addr=%h valid=%b pc=%h expected req=1 addr=00000000 valid=1 pc=fffffffc",
               w_req, w_addr, w_valid, w_inst_pc);
    end
    w_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_wait();
    test_simultaneous();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
